// File: rtl/regfile_pkg.sv
// Shared types and constants for the eight-entry register file.
package regfile_pkg;

  localparam int NUM_REGS   = 8;
  localparam int REG_ADDR_W = 3;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  localparam reg_addr_t ZERO_REG = 3'd0;

endpackage

// File: rtl/regfile8_wb_if.sv
// Write/read port bundle for regfile8_wb; the master drives writes and read indices.
interface regfile8_wb_if
  import regfile_pkg::*;
#(
  parameter int WIDTH = 64
) ();

  logic             wr_en;
  reg_addr_t        wr_addr;
  logic [WIDTH-1:0] wr_data;
  reg_addr_t        rd_addr_a;
  logic [WIDTH-1:0] rd_data_a;
  reg_addr_t        rd_addr_b;
  logic [WIDTH-1:0] rd_data_b;
  logic             wr_pending;

  modport master (
    output wr_en, wr_addr, wr_data, rd_addr_a, rd_addr_b,
    input  rd_data_a, rd_data_b, wr_pending
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_addr_a, rd_addr_b,
    output rd_data_a, rd_data_b, wr_pending
  );

endinterface

// File: rtl/regfile8_wb_decoder.sv
// 3-to-8 one-hot write-select decoder; all outputs low when en is low.
module decoder3_8 (
  input  logic [2:0] sel,
  input  logic       en,
  output logic [7:0] d
);

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_dec
      assign d[gi] = en && (sel == 3'(gi));
    end
  endgenerate

endmodule

// File: rtl/regfile8_wb.sv
// Eight-entry register file: writes are captured, then committed one edge later;
// both combinational read ports bypass the pending write.
module regfile8_wb
  import regfile_pkg::*;
#(
  parameter int WIDTH   = 64,
  parameter bit ZERO_R0 = 1'b1
) (
  input  logic          clk,
  input  logic          reset_n,
  regfile8_wb_if.slave  bus
);

  logic             pend_valid_reg;
  reg_addr_t        pend_addr_reg;
  logic [WIDTH-1:0] pend_data_reg;
  logic [WIDTH-1:0] regs_reg [NUM_REGS];

  logic [NUM_REGS-1:0] dec_d;
  logic [NUM_REGS-1:0] load_en;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_valid_reg <= 1'b0;
      pend_addr_reg  <= '0;
      pend_data_reg  <= '0;
    end else begin
      pend_valid_reg <= bus.wr_en;
      if (bus.wr_en) begin
        pend_addr_reg <= bus.wr_addr;
        pend_data_reg <= bus.wr_data;
      end
    end
  end

  decoder3_8 u_commit_dec (
    .sel (pend_addr_reg),
    .en  (pend_valid_reg),
    .d   (dec_d)
  );

  // Register 0 is hardwired to zero by never loading it.
  assign load_en = ZERO_R0 ? {dec_d[NUM_REGS-1:1], 1'b0} : dec_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs_reg[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (load_en[i]) regs_reg[i] <= pend_data_reg;
      end
    end
  end

  function automatic logic [WIDTH-1:0] read_sel(
    input reg_addr_t        addr,
    input logic [WIDTH-1:0] array_val
  );
    if (ZERO_R0 && addr == ZERO_REG)
      return '0;
    else if (pend_valid_reg && pend_addr_reg == addr)
      return pend_data_reg;
    else
      return array_val;
  endfunction

  assign bus.rd_data_a  = read_sel(bus.rd_addr_a, regs_reg[bus.rd_addr_a]);
  assign bus.rd_data_b  = read_sel(bus.rd_addr_b, regs_reg[bus.rd_addr_b]);
  assign bus.wr_pending = pend_valid_reg;

endmodule

// File: tb/tb_regfile8_wb.sv
// Directed bench for regfile8_wb: one instance with ZERO_R0=1 and one with ZERO_R0=0,
// driven identically; a monitor pops queued expectations at each falling edge.
module tb_regfile8_wb;

  logic clk;
  logic reset_n;

  regfile8_wb_if #(.WIDTH(64)) bus_z ();
  regfile8_wb_if #(.WIDTH(64)) bus_n ();

  regfile8_wb #(.WIDTH(64), .ZERO_R0(1'b1)) dut_z (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_z)
  );

  regfile8_wb #(.WIDTH(64), .ZERO_R0(1'b0)) dut_n (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [63:0] ea_z;
    logic [63:0] eb_z;
    logic [63:0] ea_n;
    logic [63:0] eb_n;
    logic        ep;
  } exp_t;

  exp_t q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  function automatic void chk(string nm, string field, logic [63:0] got, logic [63:0] req);
    if (got !== req) begin
      miscompares++;
      $display("FAIL %s %s: got %h, required %h", nm, field, got, req);
    end
  endfunction

  // Monitor: read ports are combinational, so each queued expectation is
  // checked at the falling edge of the cycle it was issued in.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (q.size() > 0) begin
        e = q.pop_front();
        vectors++;
        chk(e.name, "z.rd_data_a", bus_z.rd_data_a, e.ea_z);
        chk(e.name, "z.rd_data_b", bus_z.rd_data_b, e.eb_z);
        chk(e.name, "n.rd_data_a", bus_n.rd_data_a, e.ea_n);
        chk(e.name, "n.rd_data_b", bus_n.rd_data_b, e.eb_n);
        chk(e.name, "z.wr_pending", {63'd0, bus_z.wr_pending}, {63'd0, e.ep});
        chk(e.name, "n.wr_pending", {63'd0, bus_n.wr_pending}, {63'd0, e.ep});
        $display("vec %-14s ra=%0d rb=%0d z:%h/%h n:%h/%h pend=%b",
                 e.name, bus_z.rd_addr_a, bus_z.rd_addr_b, bus_z.rd_data_a,
                 bus_z.rd_data_b, bus_n.rd_data_a, bus_n.rd_data_b, bus_z.wr_pending);
      end
    end
  end

  // Called just after a rising edge; returns just after the next rising edge.
  task automatic cyc(input string nm, input logic we, input logic [2:0] wa,
                     input logic [63:0] wd, input logic [2:0] ra, input logic [2:0] rb,
                     input logic [63:0] eaz, input logic [63:0] ebz,
                     input logic [63:0] ean, input logic [63:0] ebn,
                     input logic ep, input bit rst_after);
    exp_t e;
    bus_z.wr_en = we;  bus_z.wr_addr = wa;  bus_z.wr_data = wd;
    bus_z.rd_addr_a = ra;  bus_z.rd_addr_b = rb;
    bus_n.wr_en = we;  bus_n.wr_addr = wa;  bus_n.wr_data = wd;
    bus_n.rd_addr_a = ra;  bus_n.rd_addr_b = rb;
    e.name = nm; e.ea_z = eaz; e.eb_z = ebz; e.ea_n = ean; e.eb_n = ebn; e.ep = ep;
    q.push_back(e);
    @(negedge clk);
    if (rst_after) begin
      #1 reset_n = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] v;
    logic [63:0] prev;
    logic [63:0] old_b;

    reset_n = 1'b0;
    bus_z.wr_en = 1'b0; bus_z.wr_addr = '0; bus_z.wr_data = '0;
    bus_z.rd_addr_a = '0; bus_z.rd_addr_b = '0;
    bus_n.wr_en = 1'b0; bus_n.wr_addr = '0; bus_n.wr_data = '0;
    bus_n.rd_addr_a = '0; bus_n.rd_addr_b = '0;
    repeat (2) @(posedge clk);
    #1;
    cyc("in_reset", 1, 3'd4, 64'h1234, 3'd4, 3'd7, 0, 0, 0, 0, 0, 0);
    reset_n = 1'b1;

    // Reset sweep over all eight addresses on both ports.
    for (int k = 0; k < 8; k += 2)
      cyc($sformatf("rst_sweep%0d", k), 0, 0, 0, 3'(k), 3'(k + 1), 0, 0, 0, 0, 0, 0);

    // Single write: same-cycle read is old, then bypass, then array.
    cyc("single_issue", 1, 3'd3, 64'hDEAD_BEEF, 3'd3, 3'd3, 0, 0, 0, 0, 0, 0);
    cyc("single_bypass", 0, 0, 0, 3'd3, 3'd3, 64'hDEAD_BEEF, 64'hDEAD_BEEF,
        64'hDEAD_BEEF, 64'hDEAD_BEEF, 1, 0);
    cyc("single_commit", 0, 0, 0, 3'd3, 3'd0, 64'hDEAD_BEEF, 0, 64'hDEAD_BEEF, 0, 0, 0);

    // Streaming writes r1..r7; port A reads the register captured last edge.
    for (int k = 1; k <= 7; k++) begin
      v     = 64'(17 * k);
      prev  = (k == 1) ? 64'd0 : 64'(17 * (k - 1));
      old_b = (k == 3) ? 64'hDEAD_BEEF : 64'd0;
      cyc($sformatf("stream_w%0d", k), 1, 3'(k), v, 3'(k - 1), 3'(k),
          prev, old_b, prev, old_b, (k != 1), 0);
    end
    cyc("stream_tail", 0, 0, 0, 3'd7, 3'd6, 64'h77, 64'h66, 64'h77, 64'h66, 1, 0);
    for (int k = 1; k <= 7; k++)
      cyc($sformatf("sweep%0d", k), 0, 0, 0, 3'(k), 3'(8 - k),
          64'(17 * k), 64'(17 * (8 - k)), 64'(17 * k), 64'(17 * (8 - k)), 0, 0);

    // Back-to-back overwrite of r5.
    cyc("ovw_a", 1, 3'd5, 64'hA, 3'd5, 3'd5, 64'h55, 64'h55, 64'h55, 64'h55, 0, 0);
    cyc("ovw_b", 1, 3'd5, 64'hB, 3'd5, 3'd5, 64'hA, 64'hA, 64'hA, 64'hA, 1, 0);
    cyc("ovw_bypass", 0, 0, 0, 3'd5, 3'd5, 64'hB, 64'hB, 64'hB, 64'hB, 1, 0);
    cyc("ovw_commit", 0, 0, 0, 3'd5, 3'd5, 64'hB, 64'hB, 64'hB, 64'hB, 0, 0);

    // r0 write: discarded with ZERO_R0=1, stored with ZERO_R0=0.
    cyc("r0_issue", 1, 3'd0, 64'hFFFF, 3'd0, 3'd0, 0, 0, 0, 0, 0, 0);
    cyc("r0_bypass", 0, 0, 0, 3'd0, 3'd0, 0, 0, 64'hFFFF, 64'hFFFF, 1, 0);
    cyc("r0_commit", 0, 0, 0, 3'd0, 3'd1, 0, 64'h11, 64'hFFFF, 64'h11, 0, 0);

    // Reset between capture and commit must drop the pending write.
    cyc("mid_capture", 1, 3'd2, 64'h55, 3'd2, 3'd2, 64'h22, 64'h22, 64'h22, 64'h22, 0, 0);
    cyc("mid_pending", 0, 0, 0, 3'd2, 3'd2, 64'h55, 64'h55, 64'h55, 64'h55, 1, 1);
    cyc("mid_in_reset", 0, 0, 0, 3'd2, 3'd5, 0, 0, 0, 0, 0, 0);
    reset_n = 1'b1;
    cyc("mid_after_r2", 0, 0, 0, 3'd2, 3'd2, 0, 0, 0, 0, 0, 0);
    cyc("mid_after_r0", 0, 0, 0, 3'd0, 3'd7, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      miscompares++;
      $display("FAIL drain: got %0d queued, required 0", q.size());
    end
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
